// File: rtl/digit_classifier_pkg.sv
// Shared definitions for the digit classifier slice.
// Holds the controller state enum, the default parameter values and the
// LED bit positions used by the top level.
// Configuration macro: DIGIT_CLASSIFIER_ACC_SAT_EN (consumed by classifier_mac_lane).
package digit_classifier_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_N_CLASS = 10;
  localparam int DEF_N_PIX   = 64;
  localparam int DEF_PIX_W   = 8;
  localparam int DEF_W_W     = 8;
  localparam int DEF_ACC_W   = 24;

  // led[7] shows busy, led[6:0] carries the zero-extended winning class
  localparam int LED_BUSY_BIT = 7;
  localparam int LED_CLASS_W  = 7;

endpackage

// File: rtl/digit_classifier_if.sv
// Pixel stream, weight ROM and result handshake bundle of the digit classifier.
// Ports (signals):
//   start, pix_valid, pix_data, w_data, result_ack : driven by the master (host side)
//   pix_ready, w_addr, busy, result_valid,
//   result_class, led                              : driven by the slave (classifier core)
interface digit_classifier_if
  import digit_classifier_pkg::*;
#(
  parameter int N_CLASS = DEF_N_CLASS,
  parameter int N_PIX   = DEF_N_PIX,
  parameter int PIX_W   = DEF_PIX_W,
  parameter int W_W     = DEF_W_W
);
  localparam int CNT_W = $clog2(N_PIX);
  localparam int CLS_W = $clog2(N_CLASS);

  logic                   start;
  logic                   pix_valid;
  logic [PIX_W-1:0]       pix_data;
  logic                   pix_ready;
  logic [CNT_W-1:0]       w_addr;
  logic [N_CLASS*W_W-1:0] w_data;
  logic                   busy;
  logic                   result_valid;
  logic [CLS_W-1:0]       result_class;
  logic                   result_ack;
  logic [7:0]             led;

  modport master (
    output start, pix_valid, pix_data, w_data, result_ack,
    input  pix_ready, w_addr, busy, result_valid, result_class, led
  );

  modport slave (
    input  start, pix_valid, pix_data, w_data, result_ack,
    output pix_ready, w_addr, busy, result_valid, result_class, led
  );

endinterface

// File: rtl/classifier_mac_lane.sv
// One class score lane: multiplies the unsigned pixel by the signed weight and
// accumulates the product into a signed ACC_W accumulator.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear accumulator (new image)
//   en         : accumulate this cycle (pixel handshake)
//   pix, w     : pixel value (unsigned), weight (signed)
//   acc        : current accumulator value
// Configuration: DIGIT_CLASSIFIER_ACC_SAT_EN defined -> accumulate clamps to
// the signed ACC_W range; undefined -> accumulate wraps modulo 2^ACC_W.
module classifier_mac_lane #(
  parameter int PIX_W = 8,
  parameter int W_W   = 8,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic [PIX_W-1:0]        pix,
  input  logic signed [W_W-1:0]   w,
  output logic signed [ACC_W-1:0] acc
);
  // One spare bit on the product and the sum keeps every intermediate exact,
  // so overflow of the ACC_W result is decided from the full-precision sum.
  localparam int PROD_W = PIX_W + W_W + 1;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

  logic signed [PROD_W-1:0] pix_x;
  logic signed [PROD_W-1:0] w_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  sum;
  logic signed [ACC_W-1:0]  acc_d;

  // Next accumulator value: exact product and sum, then either clamp or wrap
  always_comb begin
    pix_x = signed'({{(PROD_W-PIX_W){1'b0}}, pix});
    w_x   = signed'({{(PROD_W-W_W){w[W_W-1]}}, w});
    prod  = pix_x * w_x;
    sum   = SUM_W'(acc) + SUM_W'(prod);
`ifdef DIGIT_CLASSIFIER_ACC_SAT_EN
    // The sum fits when all bits above the ACC_W sign bit copy the sign
    if (sum[SUM_W-1:ACC_W-1] == {(SUM_W-ACC_W+1){sum[SUM_W-1]}}) begin
      acc_d = ACC_W'(sum);
    end else if (sum[SUM_W-1]) begin
      acc_d = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      acc_d = {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    acc_d = ACC_W'(sum);
`endif
  end

  // Accumulator register: cleared on reset and at image start, updated per handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_d;
    end
  end

endmodule

// File: rtl/digit_classifier_core.sv
// Linear digit classifier: streams N_PIX pixels, accumulates one score per
// class against weights read from an external asynchronous ROM, then scans
// the scores one class per cycle and presents the argmax until acknowledged.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : digit_classifier_if.slave (pixel stream, weight ROM, result, led)
// Configuration: DIGIT_CLASSIFIER_ACC_SAT_EN selects saturating accumulation
// inside classifier_mac_lane; default build wraps.
module digit_classifier_core
  import digit_classifier_pkg::*;
#(
  parameter int N_CLASS = DEF_N_CLASS,
  parameter int N_PIX   = DEF_N_PIX,
  parameter int PIX_W   = DEF_PIX_W,
  parameter int W_W     = DEF_W_W,
  parameter int ACC_W   = DEF_ACC_W
) (
  input logic               clk,
  input logic               rst_n,
  digit_classifier_if.slave bus
);
  localparam int CNT_W = $clog2(N_PIX);
  localparam int CLS_W = $clog2(N_CLASS);

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [CLS_W-1:0]        cls_q;
  logic [CLS_W-1:0]        best_idx_q;
  logic signed [ACC_W-1:0] best_score_q;
  logic signed [ACC_W-1:0] acc [N_CLASS];
  logic signed [ACC_W-1:0] cur_score;
  logic                    clr;
  logic                    hs;
  logic                    last_pix;
  logic                    last_cls;
  logic                    take;

  assign clr       = (state_q == IDLE) && bus.start;
  assign hs        = (state_q == ACCUM) && bus.pix_valid;
  assign last_pix  = (cnt_q == CNT_W'(N_PIX - 1));
  assign last_cls  = (cls_q == CLS_W'(N_CLASS - 1));
  assign cur_score = acc[cls_q];
  // Class 0 always seeds the running best; later classes need a strictly
  // greater score, so ties resolve to the lowest index.
  assign take      = (cls_q == '0) || (cur_score > best_score_q);

  for (genvar k = 0; k < N_CLASS; k++) begin : g_lane
    classifier_mac_lane #(
      .PIX_W(PIX_W),
      .W_W  (W_W),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .en   (hs),
      .pix  (bus.pix_data),
      .w    (bus.w_data[k*W_W +: W_W]),
      .acc  (acc[k])
    );
  end

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and the handshake/status outputs that follow the state
  always_comb begin
    state_d          = state_q;
    bus.pix_ready    = 1'b0;
    bus.busy         = 1'b0;
    bus.result_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = ACCUM;
      end
      ACCUM: begin
        bus.pix_ready = 1'b1;
        bus.busy      = 1'b1;
        if (hs && last_pix) state_d = ARGMAX;
      end
      ARGMAX: begin
        bus.busy = 1'b1;
        if (last_cls) state_d = DONE;
      end
      DONE: begin
        bus.result_valid = 1'b1;
        if (bus.result_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel counter and argmax scan registers. The pixel counter returns to 0
  // after the last pixel so w_addr never points past the ROM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      cls_q        <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
    end else begin
      if (clr) begin
        cnt_q        <= '0;
        cls_q        <= '0;
        best_idx_q   <= '0;
        best_score_q <= '0;
      end
      if (hs) begin
        cnt_q <= last_pix ? '0 : cnt_q + CNT_W'(1);
      end
      if (state_q == ARGMAX) begin
        if (take) begin
          best_score_q <= cur_score;
          best_idx_q   <= cls_q;
        end
        cls_q <= last_cls ? '0 : cls_q + CLS_W'(1);
      end
    end
  end

  assign bus.w_addr       = cnt_q;
  assign bus.result_class = (state_q == DONE) ? best_idx_q : '0;

  // LED panel: busy on the top bit, winning class only while it is valid
  always_comb begin
    bus.led               = '0;
    bus.led[LED_BUSY_BIT] = bus.busy;
    if (state_q == DONE) begin
      bus.led[LED_CLASS_W-1:0] = LED_CLASS_W'(best_idx_q);
    end
  end

endmodule

// File: tb/tb_digit_classifier_core.sv
// Scoreboard bench for digit_classifier_core. The driver pushes the class a
// plain-arithmetic reference model predicts for each image; a monitor pops
// and compares whenever result_valid rises. A second small instance covers
// the ACC_W=8 overflow case (wrap or clamp per DIGIT_CLASSIFIER_ACC_SAT_EN).
module tb_digit_classifier_core;
  import digit_classifier_pkg::*;

  localparam int N_CLASS = 10;
  localparam int N_PIX   = 4;
  localparam int PIX_W   = 8;
  localparam int W_W     = 8;
  localparam int ACC_W   = 24;

`ifdef DIGIT_CLASSIFIER_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef int img_t[16];
  typedef int rom_t[16][16];
  typedef struct {
    int     cls;
    longint hsCycle;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  longint cycle = 0;
  int     passCount = 0;
  int     checkCount = 0;
  exp_t   expQ[$];
  img_t   imgPix;
  rom_t   romMain;
  img_t   pix2;
  rom_t   rom2;

  always #5 clk = ~clk;

  // Cycle index of the period that starts at each rising edge
  always @(posedge clk) cycle <= cycle + 1;

  digit_classifier_if #(.N_CLASS(N_CLASS), .N_PIX(N_PIX), .PIX_W(PIX_W), .W_W(W_W)) bus ();
  digit_classifier_if #(.N_CLASS(2), .N_PIX(2), .PIX_W(8), .W_W(8)) bus2 ();

  digit_classifier_core #(
    .N_CLASS(N_CLASS), .N_PIX(N_PIX), .PIX_W(PIX_W), .W_W(W_W), .ACC_W(ACC_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  digit_classifier_core #(
    .N_CLASS(2), .N_PIX(2), .PIX_W(8), .W_W(8), .ACC_W(8)
  ) dut_small (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );

  // Asynchronous weight ROMs answering the current w_addr
  always_comb begin
    bus.w_data = '0;
    for (int k = 0; k < N_CLASS; k++) begin
      bus.w_data[k*W_W +: W_W] = W_W'(romMain[bus.w_addr][k]);
    end
  end

  always_comb begin
    bus2.w_data = '0;
    for (int k = 0; k < 2; k++) begin
      bus2.w_data[k*8 +: 8] = 8'(rom2[bus2.w_addr][k]);
    end
  end

  // Reference: score_k = sum over pixels of pixel*weight with each step
  // clamped or wrapped to accW bits, winner = first maximum.
  function automatic int modelClass(input img_t pix, input rom_t w, input int nPix,
                                    input int nCls, input int accW, input bit sat);
    longint acc[16];
    longint hi;
    longint lo;
    int     best;
    hi = (longint'(1) <<< (accW - 1)) - 1;
    lo = -hi - 1;
    for (int k = 0; k < 16; k++) acc[k] = 0;
    for (int p = 0; p < nPix; p++) begin
      for (int k = 0; k < nCls; k++) begin
        acc[k] += longint'(pix[p]) * longint'(w[p][k]);
        if (sat) begin
          if (acc[k] > hi) acc[k] = hi;
          else if (acc[k] < lo) acc[k] = lo;
        end else begin
          acc[k] = (acc[k] <<< (64 - accW)) >>> (64 - accW);
        end
      end
    end
    best = 0;
    for (int k = 1; k < nCls; k++) begin
      if (acc[k] > acc[best]) best = k;
    end
    return best;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Offer one pixel until accepted; returns the cycle of the handshake
  task automatic sendPixel(input int value, output longint hsCycle);
    int budget;
    budget = 0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = PIX_W'(value);
    forever begin
      @(negedge clk);
      if (bus.pix_ready) break;
      budget++;
      if (budget > 50) begin
        checkOutput("pix_ready_timeout", 0, 1);
        break;
      end
    end
    hsCycle = cycle;
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
  endtask

  // gapLen: 0 none, >0 fixed idle cycles before each pixel after the first, <0 random
  task automatic applyStimulus(input bit doStart, input int gapLen, input bit midPulse,
                               output int expCls);
    longint hs;
    exp_t   e;
    int     g;
    expCls = modelClass(imgPix, romMain, N_PIX, N_CLASS, ACC_W, SAT_EN);
    if (doStart) begin
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    for (int i = 0; i < N_PIX; i++) begin
      g = (i == 0) ? 0 : ((gapLen < 0) ? int'($urandom_range(0, 3)) : gapLen);
      if (midPulse && i == 2) begin
        bus.start      = 1'b1;
        bus.result_ack = 1'b1;
      end
      repeat (g) @(posedge clk);
      if (g > 0) #1;
      bus.start      = 1'b0;
      bus.result_ack = 1'b0;
      checkOutput("w_addr", bus.w_addr, i);
      sendPixel(imgPix[i], hs);
    end
    e.cls     = expCls;
    e.hsCycle = hs;
    expQ.push_back(e);
    checkOutput("argmax_pix_ready", bus.pix_ready, 0);
    checkOutput("argmax_busy", bus.busy, 1);
  endtask

  task automatic waitAndAck(input int hold, input bit withStart, input int expCls);
    int budget;
    budget = 0;
    while (!bus.result_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.result_valid) begin
      checkOutput("result_timeout", 0, 1);
      return;
    end
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      checkOutput("held_valid", bus.result_valid, 1);
      checkOutput("held_class", bus.result_class, expCls);
      checkOutput("held_led", bus.led, expCls);
    end
    @(posedge clk);
    #1;
    bus.result_ack = 1'b1;
    bus.start      = withStart;
    @(posedge clk);
    #1;
    bus.result_ack = 1'b0;
    bus.start      = 1'b0;
    checkOutput("valid_drops_after_ack", bus.result_valid, 0);
    if (withStart) begin
      repeat (2) @(posedge clk);
      #1;
      checkOutput("start_with_ack_busy", bus.busy, 0);
      checkOutput("start_with_ack_pix_ready", bus.pix_ready, 0);
    end
  endtask

  task automatic loadRampImage();
    for (int p = 0; p < N_PIX; p++) begin
      imgPix[p] = 1;
      for (int k = 0; k < N_CLASS; k++) romMain[p][k] = k;
    end
  endtask

  // Monitor: compare each new result against the oldest expected entry
  initial begin : monitor
    logic prevValid;
    exp_t e;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.result_valid && !prevValid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("result_class", bus.result_class, e.cls);
          checkOutput("result_led", bus.led, e.cls);
          checkOutput("result_latency", cycle - e.hsCycle, N_CLASS + 1);
        end
      end
      prevValid = bus.result_valid;
    end
  end

  initial begin : watchdog
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence of directed and random images
  initial begin : driver
    int exp;
    int budget;
    int expSmall;
    longint dummy;
    bus.start = 0; bus.pix_valid = 0; bus.pix_data = '0; bus.result_ack = 0;
    bus2.start = 0; bus2.pix_valid = 0; bus2.pix_data = '0; bus2.result_ack = 0;
    for (int p = 0; p < 16; p++) begin
      imgPix[p] = 0; pix2[p] = 0;
      for (int k = 0; k < 16; k++) begin
        romMain[p][k] = 0; rom2[p][k] = 0;
      end
    end

    // Reset values, then a start held across reset release
    loadRampImage();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_pix_ready", bus.pix_ready, 0);
    checkOutput("reset_result_valid", bus.result_valid, 0);
    checkOutput("reset_result_class", bus.result_class, 0);
    checkOutput("reset_led", bus.led, 0);
    checkOutput("reset_w_addr", bus.w_addr, 0);
    bus.start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("first_start_honoured", bus.pix_ready, 1);
    checkOutput("accum_led_busy", bus.led, 8'h80);
    applyStimulus(1'b0, 0, 1'b0, exp);
    checkOutput("model_ramp_class", exp, 9);
    waitAndAck(0, 1'b0, exp);

    // All scores tie
    for (int p = 0; p < N_PIX; p++) begin
      imgPix[p] = 3;
      for (int k = 0; k < N_CLASS; k++) romMain[p][k] = 5;
    end
    applyStimulus(1'b1, 0, 1'b0, exp);
    waitAndAck(0, 1'b0, exp);

    // Valid gaps with start and result_ack pulsed while accumulating
    loadRampImage();
    applyStimulus(1'b1, 2, 1'b1, exp);
    waitAndAck(0, 1'b0, exp);

    // Reset in the middle of an image, then a clean image
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    sendPixel(1, dummy);
    sendPixel(1, dummy);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", bus.busy, 0);
    checkOutput("midreset_pix_ready", bus.pix_ready, 0);
    checkOutput("midreset_result_valid", bus.result_valid, 0);
    checkOutput("midreset_result_class", bus.result_class, 0);
    checkOutput("midreset_led", bus.led, 0);
    checkOutput("midreset_w_addr", bus.w_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 0, 1'b0, exp);
    waitAndAck(0, 1'b0, exp);

    // Result held 20 cycles, then acknowledged together with start
    applyStimulus(1'b1, 0, 1'b0, exp);
    waitAndAck(20, 1'b1, exp);

    // Random images with random gaps and signed weights
    for (int n = 0; n < 6; n++) begin
      for (int p = 0; p < N_PIX; p++) begin
        imgPix[p] = int'($urandom_range(0, 255));
        for (int k = 0; k < N_CLASS; k++) romMain[p][k] = int'($urandom_range(0, 255)) - 128;
      end
      applyStimulus(1'b1, -1, 1'b0, exp);
      waitAndAck(0, 1'b0, exp);
    end

    // Narrow accumulator overflow on the small instance
    pix2[0] = 255; pix2[1] = 0;
    rom2[0][0] = 127; rom2[1][0] = 127;
    rom2[0][1] = 0;   rom2[1][1] = 0;
    expSmall = modelClass(pix2, rom2, 2, 2, 8, SAT_EN);
    checkOutput("model_overflow_class", expSmall, SAT_EN ? 0 : 1);
    bus2.start = 1'b1;
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      bus2.pix_valid = 1'b1;
      bus2.pix_data  = 8'(pix2[p]);
      @(negedge clk);
      checkOutput("small_pix_ready", bus2.pix_ready, 1);
      @(posedge clk);
      #1;
    end
    bus2.pix_valid = 1'b0;
    budget = 0;
    while (!bus2.result_valid && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("small_result_valid", bus2.result_valid, 1);
    checkOutput("small_result_class", bus2.result_class, expSmall);
    bus2.result_ack = 1'b1;
    @(posedge clk);
    #1;
    bus2.result_ack = 1'b0;

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/digit_classifier_core.md
DIGIT_CLASSIFIER_CORE -- requirements
Module: digit_classifier_core

Interface
REQ-001 Parameter N_CLASS, default 10, number of digit classes scored (2..16).
REQ-002 Parameter N_PIX, default 64, pixels per image (2..1024).
REQ-003 Parameter PIX_W, default 8, unsigned pixel width.
REQ-004 Parameter W_W, default 8, signed weight width.
REQ-005 Parameter ACC_W, default 24, signed accumulator width (>= 8).
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  begin new image, sampled only in IDLE.
REQ-009 pix_valid  in  1  pixel offered.
REQ-010 pix_data  in  PIX_W  pixel value.
REQ-011 pix_ready  out  1  pixel accepted when pix_valid and pix_ready are both high.
REQ-012 w_addr  out  clog2(N_PIX)  current pixel index into external asynchronous weight ROM.
REQ-013 w_data  in  N_CLASS*W_W  weights of pixel w_addr, class k at bits [k*W_W +: W_W], valid same cycle.
REQ-014 busy  out  1  high in ACCUM and ARGMAX.
REQ-015 result_valid  out  1  classification available.
REQ-016 result_class  out  clog2(N_CLASS)  winning class index.
REQ-017 result_ack  in  1  consumer accepts result.
REQ-018 led  out  8  board LEDs: led[7]=busy; led[6:0]=result_class zero-extended when result_valid, else 0.

Function
REQ-019 States SHALL be IDLE, ACCUM, ARGMAX, DONE.
REQ-020 IDLE: start high -> all accumulators and pixel counter cleared, next state ACCUM.
REQ-021 ACCUM: pix_ready=1; per handshake acc[k] += pix_data (zero-extended) * w_data[k] (signed), product sign-extended to ACC_W; counter increments.
REQ-022 Counter advances only on handshake; pix_valid gaps of any length SHALL leave accumulators and w_addr unchanged.
REQ-023 Handshake on pixel N_PIX-1 -> ARGMAX next cycle; pix_ready low from that cycle.
REQ-024 ARGMAX: one class compared per cycle, index 0..N_CLASS-1, exactly N_CLASS cycles; best replaced only on strictly greater score (ties -> lowest index).
REQ-025 Last pixel accepted at cycle t -> result_valid high at t+N_CLASS+1.
REQ-026 DONE: result_valid and result_class held stable until result_ack; result_ack -> IDLE, result_valid low next cycle.
REQ-027 start SHALL be ignored outside IDLE, including start coincident with result_ack in DONE.
REQ-028 result_ack outside DONE SHALL be ignored.
REQ-029 pix_ready SHALL be low in IDLE, ARGMAX, DONE; w_addr SHALL equal the counter in all states.

Reset
REQ-030 rst_n low at any time, including mid-ACCUM or mid-ARGMAX, SHALL immediately force IDLE, counter 0, accumulators 0, pix_ready 0, busy 0, result_valid 0, result_class 0, led 0.
REQ-031 First start honoured on first rising clk edge after rst_n deasserts.

Configuration
REQ-032 Macro DIGIT_CLASSIFIER_ACC_SAT_EN defined: each accumulate clamps to signed ACC_W max/min on overflow.
REQ-033 Macro undefined: accumulate wraps modulo 2^ACC_W (two's complement); no clamp logic synthesised.

Structure
REQ-034 Package digit_classifier_pkg SHALL hold state enum, default parameter constants, LED bit positions.
REQ-035 One sub-module classifier_mac_lane (one accumulator, multiply, optional saturation), instantiated N_CLASS times by generate.

Verification
REQ-036 N_PIX=4, pixels all 1, class k weights all k -> acc k=4k, result_class=9, result_valid exactly 11 cycles after last handshake, led=8'h09.
REQ-037 All weights 5, pixels 3 -> scores tie at 60, result_class=0.
REQ-038 pix_valid toggled 1-0-0-1 with start pulsed mid-ACCUM -> w_addr advances only on handshakes, start ignored, result identical to REQ-036.
REQ-039 ACC_W=8, N_PIX=2, pixels {255,0}, class0 weight 127, class1 weight 0 -> with DIGIT_CLASSIFIER_ACC_SAT_EN acc0=127, class 0; without acc0=-127, class 1.
REQ-040 rst_n pulsed low after 2 pixels -> all outputs 0 asynchronously; fresh start then full image gives correct result.
REQ-041 result_ack withheld 20 cycles -> outputs stable; result_ack with start same cycle -> IDLE, no new image started.
